// File: rtl/step_sched_pkg.sv
// Shared definitions for the step sequencer: width helper and FSM encoding.
package step_sched_pkg;

  // Ceiling log2 with a floor of 1 bit, so that single-value counters still get a wire.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_READ  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

endpackage

// File: rtl/step_sched_skid.sv
// Two-entry skid FIFO for the readout path; absorbs the one-cycle memory read latency.
module step_sched_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_occ
);

  logic [DW-1:0] r_mem [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  // Storage: data words carry no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_occ   = r_cnt;

endmodule

// File: rtl/step_sched.sv
// Master-side sequencer for the step elimination core: host load, pass walk, readout.
module step_sched
  import step_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 3,
  parameter int L = 8,
  parameter int K = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                go,
  output logic                                busy,
  output logic                                ok,
  output logic                                failed,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N*clog2(M)-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N*clog2(M)-1:0]               out_data,
  output logic                                out_last,
  output logic                                step_start,
  output logic [clog2(K/N+1)-1:0]             step_col_block,
  output logic                                step_functionA,
  output logic                                step_last_phase,
  output logic [clog2(L*K/N+2*N+1)-1:0]       step_first_pass_rows,
  input  logic                                step_done,
  input  logic                                step_fail,
  output logic                                step_wr_en,
  output logic [clog2(L*K/N)-1:0]             step_wr_addr,
  output logic [N*clog2(M)-1:0]               step_wr_data,
  output logic                                step_rd_en,
  output logic [clog2(L*K/N)-1:0]             step_rd_addr,
  input  logic [N*clog2(M)-1:0]               step_data_out
);

  localparam int W   = clog2(M);
  localparam int DW  = N * W;
  localparam int D   = L * K / N;
  localparam int P   = (L + N - 1) / N;
  localparam int B   = K / N;
  localparam int AW  = clog2(D);
  localparam int CW  = clog2(D + 1);
  localparam int CBW = clog2(B + 1);
  localparam int FPW = clog2(D + 2 * N + 1);
  localparam int PHW = clog2(P);
  localparam int BKW = clog2(B);

  localparam logic [CW-1:0]  C_LAST  = CW'(D - 1);
  localparam logic [CW-1:0]  C_END   = CW'(D);
  localparam logic [PHW-1:0] PH_LAST = PHW'(P - 1);
  localparam logic [BKW-1:0] BK_LAST = BKW'(B - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_wcnt;
  logic [CW-1:0]    r_rcnt;
  logic [CW-1:0]    r_ocnt;
  logic [PHW-1:0]   r_phase;
  logic [BKW-1:0]   r_blk;
  logic             r_inflight;
  logic             r_ok;
  logic             r_failed;

  logic             w_start_run;
  logic             w_in_hs;
  logic             w_load_last;
  logic [CBW-1:0]   w_phase_ext;
  logic [CBW-1:0]   w_blk_ext;
  logic             w_passA;
  logic             w_last_pass;
  logic             w_done_acc;
  logic             w_fail_hit;
  logic             w_advance;
  logic             w_pass_act;
  logic [FPW-1:0]   w_fpr;
  logic             w_rd_fire;
  logic             w_sk_valid;
  logic [DW-1:0]    w_sk_data;
  logic [1:0]       w_sk_occ;
  logic             w_out_hs;
  logic             w_out_final;

  assign w_start_run = (r_state == S_IDLE) && go;
  assign w_in_hs     = (r_state == S_LOAD) && in_valid;
  assign w_load_last = w_in_hs && (r_wcnt == C_LAST);
  assign w_phase_ext = CBW'(r_phase);
  assign w_blk_ext   = CBW'(r_blk);
  assign w_passA     = (w_phase_ext == w_blk_ext);
  assign w_last_pass = (r_phase == PH_LAST) && (r_blk == BK_LAST);
  assign w_done_acc  = (r_state == S_WAIT) && step_done;
  assign w_fail_hit  = w_done_acc && w_passA && step_fail;
  assign w_advance   = w_done_acc && !w_fail_hit && !w_last_pass;
  assign w_pass_act  = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_fpr       = FPW'(32'(r_phase) * L + N);
  assign w_rd_fire   = (r_state == S_READ) && (r_rcnt != C_END) &&
                       (({1'b0, w_sk_occ} + {2'b00, r_inflight}) < 3'd2);
  assign w_out_hs    = w_sk_valid && out_ready;
  assign w_out_final = w_out_hs && (r_ocnt == C_LAST);

  step_sched_skid #(.DW(DW)) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (r_inflight),
    .i_data  (step_data_out),
    .i_pop   (out_ready),
    .o_valid (w_sk_valid),
    .o_data  (w_sk_data),
    .o_occ   (w_sk_occ)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode; step_done is only meaningful while waiting on a pass.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_LOAD;
      S_LOAD:  if (w_load_last) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (w_fail_hit)                    w_next = S_FAIL;
        else if (w_done_acc && w_last_pass) w_next = S_READ;
        else if (w_done_acc)               w_next = S_GAP;
      end
      S_GAP:   w_next = S_ISSUE;
      S_READ:  if (w_out_final) w_next = S_IDLE;
      S_FAIL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Run counters, pass position and sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_ocnt     <= '0;
      r_phase    <= '0;
      r_blk      <= '0;
      r_inflight <= 1'b0;
      r_ok       <= 1'b0;
      r_failed   <= 1'b0;
    end else begin
      r_inflight <= w_rd_fire;
      if (w_start_run) begin
        r_wcnt   <= '0;
        r_rcnt   <= '0;
        r_ocnt   <= '0;
        r_phase  <= '0;
        r_blk    <= '0;
        r_ok     <= 1'b0;
        r_failed <= 1'b0;
      end else begin
        if (w_in_hs)   r_wcnt <= r_wcnt + CW'(1);
        if (w_rd_fire) r_rcnt <= r_rcnt + CW'(1);
        if (w_out_hs)  r_ocnt <= r_ocnt + CW'(1);
        if (w_advance) begin
          if (r_blk == BK_LAST) begin
            r_phase <= r_phase + PHW'(1);
            r_blk   <= BKW'(w_phase_ext + CBW'(1));
          end else begin
            r_blk   <= r_blk + BKW'(1);
          end
        end
        if (w_fail_hit)  r_failed <= 1'b1;
        if (w_out_final) r_ok     <= 1'b1;
      end
    end
  end

  // Output decode; pass fields are only driven while a pass is issued or outstanding.
  always_comb begin
    busy                 = (r_state != S_IDLE) && (r_state != S_FAIL);
    ok                   = r_ok;
    failed               = r_failed;
    in_ready             = (r_state == S_LOAD);
    step_wr_en           = w_in_hs;
    step_wr_addr         = w_in_hs ? r_wcnt[AW-1:0] : '0;
    step_wr_data         = w_in_hs ? in_data : '0;
    step_start           = (r_state == S_ISSUE);
    step_col_block       = w_pass_act ? w_blk_ext : '0;
    step_functionA       = w_pass_act && w_passA;
    step_last_phase      = w_pass_act && (r_phase == PH_LAST);
    step_first_pass_rows = w_pass_act ? w_fpr : '0;
    step_rd_en           = w_rd_fire;
    step_rd_addr         = w_rd_fire ? r_rcnt[AW-1:0] : '0;
    out_valid            = w_sk_valid;
    out_data             = w_sk_valid ? w_sk_data : '0;
    out_last             = w_sk_valid && (r_ocnt == C_LAST);
  end

endmodule

// File: tb/tb_step_sched.sv
// Bench for step_sched: behavioural step responder and memory, reference pass list and readout.
module tb_step_sched;

  localparam int N = 4, M = 3, L = 8, K = 16;
  localparam int DW = 8, D = 32, AW = 5, CBW = 3, FPW = 6, P = 2, B = 4;
  localparam int RESP_LAT = L + 2 * N + 2;

  typedef struct {
    int cb;
    int a;
    int lp;
    int fpr;
  } pass_t;

  logic clk, rst, go, busy, ok, failed;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data, out_data;
  logic step_start, step_functionA, step_last_phase, step_done, step_fail;
  logic [CBW-1:0] step_col_block;
  logic [FPW-1:0] step_first_pass_rows;
  logic step_wr_en, step_rd_en;
  logic [AW-1:0] step_wr_addr, step_rd_addr;
  logic [DW-1:0] step_wr_data, step_data_out;

  logic resp_done, resp_fail, inj_done;
  logic [DW-1:0] rdq;
  logic [DW-1:0] smem [D];
  logic [DW-1:0] hw [D];
  pass_t plog[$];
  pass_t exp_pass[$];
  logic [DW-1:0] got_d[$];
  logic got_l[$];

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int fail_cb_a = -1;
  int fail_cb_b = -1;
  bit gap_viol = 0, unstable = 0, overlap = 0;
  bit rbusy, prev_done;
  int rcnt;
  int cap_cb, cap_a, cap_lp, cap_fpr;

  assign step_done = resp_done | inj_done;
  assign step_fail = resp_fail;
  assign step_data_out = rdq;

  step_sched dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .ok(ok), .failed(failed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .step_start(step_start), .step_col_block(step_col_block), .step_functionA(step_functionA),
    .step_last_phase(step_last_phase), .step_first_pass_rows(step_first_pass_rows),
    .step_done(step_done), .step_fail(step_fail),
    .step_wr_en(step_wr_en), .step_wr_addr(step_wr_addr), .step_wr_data(step_wr_data),
    .step_rd_en(step_rd_en), .step_rd_addr(step_rd_addr), .step_data_out(step_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // step data memory: write port plus one-cycle registered read.
  always @(posedge clk) begin
    if (step_wr_en) smem[step_wr_addr] <= step_wr_data;
    if (step_rd_en) rdq <= smem[step_rd_addr];
    if (step_wr_en && step_rd_en) overlap <= 1'b1;
  end

  // step pass responder: done a fixed latency after start, optional fail per column block.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbusy <= 1'b0; rcnt <= 0; resp_done <= 1'b0; resp_fail <= 1'b0; prev_done <= 1'b0;
    end else begin
      prev_done <= step_done;
      resp_done <= 1'b0;
      resp_fail <= 1'b0;
      if (step_start) begin
        if (rbusy) unstable <= 1'b1;
        if (prev_done || step_done) gap_viol <= 1'b1;
        plog.push_back('{int'(step_col_block), int'(step_functionA),
                         int'(step_last_phase), int'(step_first_pass_rows)});
        cap_cb <= int'(step_col_block); cap_a <= int'(step_functionA);
        cap_lp <= int'(step_last_phase); cap_fpr <= int'(step_first_pass_rows);
        starts <= starts + 1;
        rbusy <= 1'b1;
        rcnt <= RESP_LAT;
      end else if (rbusy) begin
        if (int'(step_col_block) != cap_cb || int'(step_functionA) != cap_a ||
            int'(step_last_phase) != cap_lp || int'(step_first_pass_rows) != cap_fpr)
          unstable <= 1'b1;
        if (rcnt <= 1) begin
          resp_done <= 1'b1;
          resp_fail <= (cap_a == 1 && cap_cb == fail_cb_a) || (cap_a == 0 && cap_cb == fail_cb_b);
          rbusy <= 1'b0;
        end else begin
          rcnt <= rcnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ok"}, ok, 0);
    chk({tag, "_failed"}, failed, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_start"}, step_start, 0);
    chk({tag, "_col_block"}, step_col_block, 0);
    chk({tag, "_functionA"}, step_functionA, 0);
    chk({tag, "_last_phase"}, step_last_phase, 0);
    chk({tag, "_fpr"}, step_first_pass_rows, 0);
    chk({tag, "_wr_en"}, step_wr_en, 0);
    chk({tag, "_rd_en"}, step_rd_en, 0);
  endtask

  task automatic start_run();
    for (int i = 0; i < D; i++) hw[i] = DW'($urandom);
    got_d.delete();
    got_l.delete();
    chk("idle_before_go", busy, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("busy_after_go", busy, 1);
  endtask

  // Hold in_valid for the whole load; optionally poke go and step_done mid-load.
  task automatic run_load(input bit inject);
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1;
      in_data = hw[i];
      go = inject && (i == 5);
      inj_done = inject && (i == 9);
      #1;
      chk("in_ready", in_ready, 1);
      chk("wr_en", step_wr_en, 1);
      chk("wr_addr", step_wr_addr, i);
      chk("wr_data", step_wr_data, hw[i]);
      chk("no_start_in_load", step_start, 0);
      tick();
    end
    in_valid = 1'b0;
    go = 1'b0;
    inj_done = 1'b0;
    #1;
    chk("start_after_load", step_start, 1);
    chk("wr_en_after_load", step_wr_en, 0);
  endtask

  // Random 30% out_ready until busy drops or the cycle budget runs out.
  task automatic run_rest(input bit inject);
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 9) < 3);
      go = inject && (c == 30 || c == 200);
      #1;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      tick();
      if (!busy) break;
    end
    out_ready = 1'b0;
    go = 1'b0;
    chk("run_end_busy", busy, 0);
  endtask

  task automatic check_passes(input int base, input int n);
    chk("pass_count", plog.size() - base, n);
    for (int i = 0; i < n && base + i < plog.size(); i++) begin
      chk($sformatf("pass%0d_cb", i), plog[base + i].cb, exp_pass[i].cb);
      chk($sformatf("pass%0d_A", i), plog[base + i].a, exp_pass[i].a);
      chk($sformatf("pass%0d_lp", i), plog[base + i].lp, exp_pass[i].lp);
      chk($sformatf("pass%0d_fpr", i), plog[base + i].fpr, exp_pass[i].fpr);
    end
  endtask

  task automatic check_readout();
    chk("read_count", got_d.size(), D);
    for (int i = 0; i < got_d.size() && i < D; i++) begin
      chk($sformatf("read%0d_data", i), got_d[i], hw[i]);
      chk($sformatf("read%0d_last", i), got_l[i], (i == D - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int base;
    int s0;
    rst = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; inj_done = 1'b0;

    // Reference pass order: pivot on block p, then apply on every later block.
    for (int p = 0; p < P; p++) begin
      exp_pass.push_back('{p, 1, (p == P - 1) ? 1 : 0, (p * L + N) % (1 << FPW)});
      for (int b = p + 1; b < B; b++)
        exp_pass.push_back('{b, 0, (p == P - 1) ? 1 : 0, (p * L + N) % (1 << FPW)});
    end

    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Run 1: clean run with ignored go/done pokes and ignored fail on an apply pass.
    fail_cb_b = 2;
    base = plog.size();
    start_run();
    run_load(1'b1);
    run_rest(1'b1);
    chk("r1_ok", ok, 1);
    chk("r1_failed", failed, 0);
    check_passes(base, 7);
    check_readout();

    // Run 2: pivot failure on the phase-1 pivot pass.
    fail_cb_b = -1;
    fail_cb_a = 1;
    base = plog.size();
    start_run();
    chk("r2_ok_cleared", ok, 0);
    run_load(1'b0);
    run_rest(1'b0);
    chk("r2_failed", failed, 1);
    chk("r2_ok", ok, 0);
    chk("r2_no_readout", got_d.size(), 0);
    check_passes(base, 5);
    s0 = starts;
    repeat (40) tick();
    chk("r2_no_more_start", starts, s0);
    chk("r2_busy_idle", busy, 0);

    // Run 3: reset while waiting on the first pass.
    fail_cb_a = -1;
    start_run();
    chk("r3_failed_cleared", failed, 0);
    run_load(1'b0);
    repeat (6) tick();
    chk("r3_wait_functionA", step_functionA, 1);
    chk("r3_wait_fpr", step_first_pass_rows, N);
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    rst = 1'b1;
    tick();

    // Run 4: fresh run after reset starts from address 0 and completes.
    base = plog.size();
    start_run();
    run_load(1'b0);
    run_rest(1'b0);
    chk("r4_ok", ok, 1);
    chk("r4_failed", failed, 0);
    check_passes(base, 7);
    check_readout();

    chk("gap_between_done_start", gap_viol, 0);
    chk("pass_fields_stable", unstable, 0);
    chk("wr_rd_exclusive", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
